// File: rtl/mvm_pkg.sv
// Shared definitions for the mvm ingress path: tuser layout, op codes and scheduler states.
package mvm_pkg;

   localparam int ADDR_W   = 9;
   localparam int OP_W     = 2;
   localparam int MASK_W   = 64;
   localparam int ADDR_LSB = 0;
   localparam int OP_LSB   = ADDR_LSB + ADDR_W;
   localparam int MASK_LSB = OP_LSB + OP_W;
   localparam int TUSER_W  = MASK_LSB + MASK_W;

   typedef enum logic [OP_W-1:0] {
      OP_INSTR  = 2'h0,
      OP_REDUCE = 2'h1,
      OP_INPUT  = 2'h2,
      OP_MATRIX = 2'h3
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_CFG,
      ST_RUN,
      ST_DRAIN
   } sched_state_e;

   function automatic logic [TUSER_W-1:0] pack_tuser(input logic [MASK_W-1:0] mask,
                                                     input op_e               op,
                                                     input logic [ADDR_W-1:0] addr);
      return {mask, op, addr};
   endfunction

endpackage

// File: rtl/axis_pipe_reg.sv
// One-entry valid/ready register slice; accepts whenever empty or being drained.
module axis_pipe_reg #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         s_valid_i,
   output logic         s_ready_o,
   input  logic [W-1:0] s_data_i,
   output logic         m_valid_o,
   input  logic         m_ready_i,
   output logic [W-1:0] m_data_o
);

   logic         valid_q;
   logic [W-1:0] data_q;

   assign s_ready_o = !valid_q || m_ready_i;
   assign m_valid_o = valid_q;
   assign m_data_o  = data_q;

   // NOTE: the payload is reset as well so the downstream port shows all-zero data out of reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else if (s_ready_o) begin
         // NOTE: non-blocking so every flop samples the pre-edge values of its inputs.
         valid_q <= s_valid_i;
         if (s_valid_i) data_q <= s_data_i;
      end
   end

endmodule

// File: rtl/mvm_ingress_sched.sv
// Merges the mvm config stream and credit-gated input vectors into the mvm rx port.
// Optional statistics counters are built only when MVM_SCHED_STATS_EN is defined.
module mvm_ingress_sched
   import mvm_pkg::*;
#(
   parameter int DATAW             = 512,
   parameter int USERW             = 75,
   parameter int VECS_PER_BATCH    = 2,
   parameter int RESULTS_PER_BATCH = 4,
   parameter int MAX_BATCHES       = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cfg_tvalid,
   output logic             cfg_tready,
   input  logic [DATAW-1:0] cfg_tdata,
   input  logic [USERW-1:0] cfg_tuser,
   input  logic             cfg_tlast,
   input  logic             vec_tvalid,
   output logic             vec_tready,
   input  logic [DATAW-1:0] vec_tdata,
   output logic             m_tvalid,
   input  logic             m_tready,
   output logic [DATAW-1:0] m_tdata,
   output logic [USERW-1:0] m_tuser,
   input  logic             mon_tvalid,
   input  logic             mon_tready,
   output logic             busy,
   output logic [31:0]      stat_vecs,
   output logic [31:0]      stat_batches,
   output logic [31:0]      stat_stalls
);

   localparam int VCW = (VECS_PER_BATCH > 1) ? $clog2(VECS_PER_BATCH) : 1;
   localparam int RCW = (RESULTS_PER_BATCH > 1) ? $clog2(RESULTS_PER_BATCH) : 1;
   localparam logic [USERW-1:0] VEC_TUSER = USERW'(pack_tuser('0, OP_INPUT, '0));

   sched_state_e     state_q;
   logic [VCW-1:0]   vec_cnt_q, vec_cnt_d;
   logic [RCW-1:0]   res_cnt_q, res_cnt_d;
   logic [7:0]       outstanding_q, outstanding_d;

   logic                   pipe_ready, pipe_valid;
   logic [DATAW+USERW-1:0] pipe_data, pipe_out;
   logic                   credit_ok, drain_req;
   logic                   cfg_fire, vec_fire, mon_fire, vec_wrap, res_wrap;

   assign credit_ok = outstanding_q < 8'(MAX_BATCHES);
   // Once a config is waiting at a batch boundary, no new batch may start.
   assign drain_req = cfg_tvalid && (vec_cnt_q == '0);

   assign cfg_tready = (state_q == ST_CFG) && pipe_ready;
   assign vec_tready = (state_q == ST_RUN) && pipe_ready && credit_ok && !drain_req;

   assign cfg_fire = cfg_tvalid && cfg_tready;
   assign vec_fire = vec_tvalid && vec_tready;
   assign mon_fire = mon_tvalid && mon_tready;
   assign vec_wrap = vec_fire && (vec_cnt_q == VCW'(VECS_PER_BATCH - 1));
   assign res_wrap = mon_fire && (res_cnt_q == RCW'(RESULTS_PER_BATCH - 1));

   assign busy = (state_q != ST_CFG) && !((state_q == ST_IDLE) && (outstanding_q == '0));

   // NOTE: every next-state value gets a default first so no latch can be inferred.
   always_comb begin
      vec_cnt_d     = vec_cnt_q;
      res_cnt_d     = res_cnt_q;
      outstanding_d = outstanding_q;
      if (vec_fire) vec_cnt_d = vec_wrap ? '0 : vec_cnt_q + VCW'(1);
      if (mon_fire) res_cnt_d = res_wrap ? '0 : res_cnt_q + RCW'(1);
      // A result wrap with nothing outstanding is a protocol error; the count saturates.
      case ({vec_wrap, res_wrap})
         2'b10:   outstanding_d = outstanding_q + 8'd1;
         2'b01:   if (outstanding_q != '0) outstanding_d = outstanding_q - 8'd1;
         default: outstanding_d = outstanding_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vec_cnt_q     <= '0;
         res_cnt_q     <= '0;
         outstanding_q <= '0;
      end else begin
         vec_cnt_q     <= vec_cnt_d;
         res_cnt_q     <= res_cnt_d;
         outstanding_q <= outstanding_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE:  if (cfg_tvalid) state_q <= ST_CFG;
            ST_CFG:   if (cfg_fire && cfg_tlast) state_q <= ST_RUN;
            ST_RUN:   if (drain_req) state_q <= ST_DRAIN;
            ST_DRAIN: if (outstanding_q == '0) state_q <= ST_CFG;
            default:  state_q <= ST_IDLE;
         endcase
      end
   end

   assign pipe_valid = cfg_fire || vec_fire;
   assign pipe_data  = cfg_fire ? {cfg_tdata, cfg_tuser} : {vec_tdata, VEC_TUSER};

   axis_pipe_reg #(.W(DATAW + USERW)) u_out_stage (
      .clk       (clk),
      .rst_n     (rst_n),
      .s_valid_i (pipe_valid),
      .s_ready_o (pipe_ready),
      .s_data_i  (pipe_data),
      .m_valid_o (m_tvalid),
      .m_ready_i (m_tready),
      .m_data_o  (pipe_out)
   );

   assign m_tdata = pipe_out[DATAW+USERW-1:USERW];
   assign m_tuser = pipe_out[USERW-1:0];

`ifdef MVM_SCHED_STATS_EN
   logic [31:0] stat_vecs_q, stat_batches_q, stat_stalls_q;
   logic        batch_retired;

   assign batch_retired = res_wrap && ((outstanding_q != '0) || vec_wrap);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_vecs_q    <= '0;
         stat_batches_q <= '0;
         stat_stalls_q  <= '0;
      end else begin
         stat_vecs_q    <= stat_vecs_q + 32'(vec_fire);
         stat_batches_q <= stat_batches_q + 32'(batch_retired);
         stat_stalls_q  <= stat_stalls_q + 32'(vec_tvalid && !credit_ok);
      end
   end

   assign stat_vecs    = stat_vecs_q;
   assign stat_batches = stat_batches_q;
   assign stat_stalls  = stat_stalls_q;
`else
   assign stat_vecs    = '0;
   assign stat_batches = '0;
   assign stat_stalls  = '0;
`endif

endmodule

// File: tb/tb_mvm_ingress_sched.sv
// Randomized scoreboard bench for mvm_ingress_sched against a batch-counting reference model.
module tb_mvm_ingress_sched;
   import mvm_pkg::*;

   localparam int DATAW = 512;
   localparam int USERW = 75;
   localparam int VPB   = 2;
   localparam int RPB   = 4;
   localparam int MAXB  = 4;
   localparam logic [USERW-1:0] VEC_USER = {64'h0, 2'h2, 9'h0};

   logic             clk = 1'b0;
   logic             rst_n;
   logic             cfg_tvalid, cfg_tready, cfg_tlast;
   logic [DATAW-1:0] cfg_tdata;
   logic [USERW-1:0] cfg_tuser;
   logic             vec_tvalid, vec_tready;
   logic [DATAW-1:0] vec_tdata;
   logic             m_tvalid, m_tready;
   logic [DATAW-1:0] m_tdata;
   logic [USERW-1:0] m_tuser;
   logic             mon_tvalid, mon_tready;
   logic             busy;
   logic [31:0]      stat_vecs, stat_batches, stat_stalls;

   always #5 clk = ~clk;

   mvm_ingress_sched #(
      .DATAW(DATAW), .USERW(USERW), .VECS_PER_BATCH(VPB),
      .RESULTS_PER_BATCH(RPB), .MAX_BATCHES(MAXB)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .cfg_tvalid(cfg_tvalid), .cfg_tready(cfg_tready), .cfg_tdata(cfg_tdata),
      .cfg_tuser(cfg_tuser), .cfg_tlast(cfg_tlast),
      .vec_tvalid(vec_tvalid), .vec_tready(vec_tready), .vec_tdata(vec_tdata),
      .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata), .m_tuser(m_tuser),
      .mon_tvalid(mon_tvalid), .mon_tready(mon_tready), .busy(busy),
      .stat_vecs(stat_vecs), .stat_batches(stat_batches), .stat_stalls(stat_stalls)
   );

   typedef struct {
      logic [DATAW-1:0] d;
      logic [USERW-1:0] u;
      int               c;
   } beat_t;

   beat_t sb[$];
   int    n_checks = 0, n_fail = 0, cyc = 0;
   int    vecs = 0, res = 0, cfgs = 0, pushed = 0, beats_out = 0, stalls = 0;
   bit    lat_chk = 1'b1, bp_en = 1'b0;
   bit    last_vec_acc, last_cfg_acc, last_vec_ready;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference model: batches sent minus batches retired, from raw beat counts.
   function automatic int outst_m();
      return vecs / VPB - res / RPB;
   endfunction

   function automatic logic [DATAW-1:0] rand_data();
      logic [DATAW-1:0] r;
      for (int i = 0; i < DATAW / 32; i++) r[i*32 +: 32] = $urandom;
      return r;
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) if (bp_en) begin
      #1 m_tready = ($urandom_range(0, 1) == 1);
   end

   // Monitor: pops the scoreboard whenever a beat leaves the DUT, and checks held beats stay put.
   logic                   held;
   logic [DATAW+USERW-1:0] held_v;
   beat_t                  mon_e;
   always @(negedge clk) begin
      if (!rst_n) begin
         held <= 1'b0;
      end else begin
         if (held) begin
            check("hold_valid", 64'(m_tvalid), 64'd1);
            check("hold_stable", 64'({m_tdata, m_tuser} == held_v), 64'd1);
         end
         if (m_tvalid && m_tready) begin
            if (sb.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_beat: got tuser %0h with empty scoreboard", m_tuser);
            end else begin
               mon_e = sb.pop_front();
               check("beat_tuser", 64'(m_tuser), 64'(mon_e.u));
               n_checks++;
               if (m_tdata !== mon_e.d) begin
                  n_fail++;
                  $display("FAIL beat_tdata: got low word %0h expected %0h", m_tdata[63:0], mon_e.d[63:0]);
               end
               if (lat_chk) check("latency", 64'(cyc - mon_e.c), 64'd1);
               beats_out++;
            end
         end
         held   <= m_tvalid && !m_tready;
         held_v <= {m_tdata, m_tuser};
      end
   end

   // One clock of stimulus: sample handshakes at the falling edge, then move past the rising edge.
   task automatic step(input bit chk_vr);
      beat_t b;
      @(negedge clk);
      if (chk_vr)
         check("vec_tready", 64'(vec_tready), 64'((!m_tvalid || m_tready) && (outst_m() < MAXB)));
      last_vec_ready = vec_tready;
      last_vec_acc   = vec_tvalid && vec_tready;
      last_cfg_acc   = cfg_tvalid && cfg_tready;
      if (vec_tvalid && outst_m() >= MAXB) stalls++;
      if (last_vec_acc) begin
         b.d = vec_tdata; b.u = VEC_USER; b.c = cyc;
         sb.push_back(b); vecs++; pushed++;
      end
      if (last_cfg_acc) begin
         b.d = cfg_tdata; b.u = cfg_tuser; b.c = cyc;
         sb.push_back(b); cfgs++; pushed++;
      end
      if (mon_tvalid && mon_tready) res++;
      @(posedge clk);
      #1;
      if (last_vec_acc) vec_tdata = rand_data();
   endtask

   task automatic send_cfg(input op_e op, input bit last);
      bit done = 1'b0;
      cfg_tvalid = 1'b1;
      cfg_tdata  = rand_data();
      cfg_tuser  = pack_tuser({$urandom, $urandom}, op, 9'($urandom));
      cfg_tlast  = last;
      for (int k = 0; k < 100 && !done; k++) begin
         step(1'b0);
         done = last_cfg_acc;
      end
      check("cfg_accept_timeout", 64'(done), 64'd1);
      cfg_tvalid = 1'b0;
      cfg_tlast  = 1'b0;
   endtask

   task automatic send_vec();
      bit done = 1'b0;
      vec_tvalid = 1'b1;
      for (int k = 0; k < 100 && !done; k++) begin
         step(1'b0);
         done = last_vec_acc;
      end
      check("vec_accept_timeout", 64'(done), 64'd1);
      vec_tvalid = 1'b0;
   endtask

   task automatic results(input int n);
      mon_tvalid = 1'b1;
      mon_tready = 1'b1;
      for (int k = 0; k < n; k++) step(1'b0);
      mon_tvalid = 1'b0;
   endtask

   initial begin
      #1_000_000;
      n_checks++;
      n_fail++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      int vecs_before, cfgs_before, target, guard;
      rst_n = 1'b0;
      cfg_tvalid = 1'b0; cfg_tlast = 1'b0; cfg_tdata = '0; cfg_tuser = '0;
      vec_tvalid = 1'b0; vec_tdata = rand_data();
      mon_tvalid = 1'b0; mon_tready = 1'b0; m_tready = 1'b1;

      // Reset values
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_m_tvalid", 64'(m_tvalid), 64'd0);
      check("rst_m_tdata_zero", 64'(m_tdata == '0), 64'd1);
      check("rst_m_tuser", 64'(m_tuser), 64'd0);
      check("rst_cfg_tready", 64'(cfg_tready), 64'd0);
      check("rst_vec_tready", 64'(vec_tready), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_stat_vecs", 64'(stat_vecs), 64'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Vectors with no config are held off
      vec_tvalid = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         check("idle_vec_tready", 64'(vec_tready), 64'd0);
         check("idle_m_tvalid", 64'(m_tvalid), 64'd0);
         @(posedge clk);
         #1;
      end
      vec_tvalid = 1'b0;

      // Config pass-through: instruction config then a matrix config (goes via DRAIN)
      for (int i = 0; i < 8; i++) send_cfg(OP_INSTR, i == 7);
      check("state_run_after_cfg", 64'(dut.state_q), 64'(ST_RUN));
      for (int i = 0; i < 8; i++) send_cfg(OP_MATRIX, i == 7);
      check("state_run_after_matrix", 64'(dut.state_q), 64'(ST_RUN));
      step(1'b0);
      check("cfg_beats_out", 64'(beats_out), 64'd16);

      // Credit limit: no results, continuous vectors
      vec_tvalid = 1'b1;
      for (int i = 0; i < 30; i++) step(1'b1);
      check("credit_vec_count", 64'(vecs), 64'(MAXB * VPB));
      check("credit_blocked", 64'(last_vec_ready), 64'd0);
      mon_tready = 1'b1;
      mon_tvalid = 1'b1;
      for (int i = 0; i < RPB; i++) step(1'b1);
      mon_tvalid = 1'b0;
      for (int i = 0; i < 10; i++) step(1'b1);
      check("credit_after_retire", 64'(vecs), 64'((MAXB + 1) * VPB));
      vec_tvalid = 1'b0;

      // Simultaneous batch wrap and result wrap at outstanding == 2
      results(2 * RPB);
      check("outstanding_before_simul", 64'(dut.outstanding_q), 64'(outst_m()));
      send_vec();
      results(RPB - 1);
      vec_tvalid = 1'b1;
      mon_tvalid = 1'b1;
      step(1'b0);
      check("simul_vec_accepted", 64'(last_vec_acc), 64'd1);
      vec_tvalid = 1'b0;
      mon_tvalid = 1'b0;
      step(1'b0);
      check("simul_outstanding", 64'(dut.outstanding_q), 64'(outst_m()));

      // Reconfigure mid-batch: the partial batch completes, then DRAIN until results return
      send_vec();
      vecs_before = vecs;
      cfgs_before = cfgs;
      cfg_tvalid = 1'b1; cfg_tlast = 1'b1; cfg_tdata = rand_data();
      cfg_tuser  = pack_tuser({$urandom, $urandom}, OP_INSTR, 9'($urandom));
      vec_tvalid = 1'b1;
      for (int i = 0; i < 10; i++) step(1'b0);
      vec_tvalid = 1'b0;
      check("reconf_one_more_vec", 64'(vecs - vecs_before), 64'd1);
      check("reconf_state_drain", 64'(dut.state_q), 64'(ST_DRAIN));
      check("reconf_busy", 64'(busy), 64'd1);
      results(outst_m() * RPB - 1);
      for (int i = 0; i < 3; i++) step(1'b0);
      check("drain_holds_cfg", 64'(cfgs - cfgs_before), 64'd0);
      results(1);
      guard = 0;
      while (cfgs == cfgs_before && guard < 10) begin
         step(1'b0);
         guard++;
      end
      check("drain_releases_cfg", 64'(cfgs - cfgs_before), 64'd1);
      check("outstanding_zero", 64'(dut.outstanding_q), 64'd0);
      cfg_tvalid = 1'b0;
      cfg_tlast  = 1'b0;
      check("state_run_after_reconf", 64'(dut.state_q), 64'(ST_RUN));

      // Backpressure with random results; order and count checked by the scoreboard
      lat_chk = 1'b0;
      bp_en   = 1'b1;
      target  = vecs + 60;
      guard   = 0;
      while (vecs < target && guard < 4000) begin
         if (last_vec_acc || !vec_tvalid) vec_tvalid = ($urandom_range(0, 3) != 0);
         mon_tvalid = (res < (vecs / VPB) * RPB) && ($urandom_range(0, 1) == 1);
         mon_tready = ($urandom_range(0, 3) != 0);
         step(1'b1);
         guard++;
      end
      check("bp_progress", 64'(vecs >= target), 64'd1);
      bp_en      = 1'b0;
      vec_tvalid = 1'b0;
      mon_tvalid = 1'b0;
      step(1'b0);
      m_tready = 1'b1;
      guard = 0;
      while (sb.size() != 0 && guard < 20) begin
         step(1'b0);
         guard++;
      end
      check("sb_empty", 64'(sb.size()), 64'd0);
      check("beats_out_total", 64'(beats_out), 64'(pushed));

`ifdef MVM_SCHED_STATS_EN
      check("stat_vecs", 64'(stat_vecs), 64'(vecs));
      check("stat_batches", 64'(stat_batches), 64'(res / RPB));
      check("stat_stalls", 64'(stat_stalls), 64'(stalls));
`else
      check("stat_vecs_tied", 64'(stat_vecs), 64'd0);
      check("stat_batches_tied", 64'(stat_batches), 64'd0);
      check("stat_stalls_tied", 64'(stat_stalls), 64'd0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
